// File: rtl/mdsa_out_streamer.sv
// Output streamer for the matrix sorter: captures one sorted N x N frame and
// replays it element by element, row-major, over a valid/ready stream.
module mdsa_out_streamer #(
  parameter int N  = 8,
  parameter int DW = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [N*N*DW-1:0]    data_in,
  input  logic                 output_enable,
  input  logic                 m_ready,
  input  logic                 clr_ovf,
  output logic                 m_valid,
  output logic [DW-1:0]        m_data,
  output logic [$clog2(N)-1:0] m_row,
  output logic [$clog2(N)-1:0] m_col,
  output logic                 m_last,
  output logic                 busy,
  output logic                 done,
  output logic                 ovf
);

  localparam int NE = N * N;
  localparam int KW = $clog2(NE);
  localparam int RW = $clog2(N);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic [KW-1:0] K_LAST = KW'(NE - 1);
  localparam logic [KW-1:0] K_N    = KW'(N);

  logic [1:0]        state;
  logic [KW-1:0]     k_p0;
  logic [NE*DW-1:0]  frame_p0;
  logic              ovf_p0;
  logic              vld_p0;
  logic              capture;
  logic              overrun;
  logic              xfer;

  function automatic logic [DW-1:0] elem_sel(input logic [NE*DW-1:0] frame,
                                             input logic [KW-1:0]    idx);
    return frame[DW*int'(idx) +: DW];
  endfunction

  assign capture = en && output_enable && (state == S_IDLE);
  assign overrun = en && output_enable && (state != S_IDLE);
  assign vld_p0  = en && (state == S_STREAM);
  assign xfer    = vld_p0 && m_ready;

  // Control: frame state machine and element index
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
      k_p0  <= '0;
    end else if (en) begin
      case (state)
        S_IDLE: begin
          if (output_enable) begin
            state <= S_STREAM;
            k_p0  <= '0;
          end
        end
        S_STREAM: begin
          if (xfer) begin
            k_p0 <= k_p0 + KW'(1);
            if (k_p0 == K_LAST) state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Frame storage; a strobe arriving while a frame is held is dropped
  always_ff @(posedge clk) begin
    if (!rst) begin
      frame_p0 <= '0;
    end else if (capture) begin
      frame_p0 <= data_in;
    end
  end

  // Overrun flag: a new overrun beats a simultaneous clear
  always_ff @(posedge clk) begin
    if (!rst) begin
      ovf_p0 <= 1'b0;
    end else if (overrun) begin
      ovf_p0 <= 1'b1;
    end else if (en && clr_ovf) begin
      ovf_p0 <= 1'b0;
    end
  end

  logic [KW-1:0] row_full;
  logic [KW-1:0] col_full;

  assign row_full = k_p0 / K_N;
  assign col_full = k_p0 % K_N;

  always_comb begin
    m_data = '0;
    m_row  = '0;
    m_col  = '0;
    m_last = 1'b0;
    if (vld_p0) begin
      m_data = elem_sel(frame_p0, k_p0);
      m_row  = row_full[RW-1:0];
      m_col  = col_full[RW-1:0];
      m_last = (k_p0 == K_LAST);
    end
  end

  assign m_valid = vld_p0;
  assign busy    = (state != S_IDLE);
  assign done    = en && (state == S_DONE);
  assign ovf     = ovf_p0;

endmodule

// File: tb/tb_mdsa_out_streamer.sv
// Directed bench for mdsa_out_streamer: a per-cycle vector table for the start
// of a frame, then hand-written sequences for stalls, overrun, pause, reset, back-to-back.
module tb_mdsa_out_streamer;

  localparam int N  = 8;
  localparam int DW = 32;
  localparam int NE = N * N;
  localparam int RW = $clog2(N);

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              en = 1'b0;
  logic              output_enable = 1'b0;
  logic              m_ready = 1'b0;
  logic              clr_ovf = 1'b0;
  logic [NE*DW-1:0]  data_in = '0;
  logic              m_valid;
  logic [DW-1:0]     m_data;
  logic [RW-1:0]     m_row;
  logic [RW-1:0]     m_col;
  logic              m_last;
  logic              busy;
  logic              done;
  logic              ovf;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mdsa_out_streamer #(.N(N), .DW(DW)) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .data_in       (data_in),
    .output_enable (output_enable),
    .m_ready       (m_ready),
    .clr_ovf       (clr_ovf),
    .m_valid       (m_valid),
    .m_data        (m_data),
    .m_row         (m_row),
    .m_col         (m_col),
    .m_last        (m_last),
    .busy          (busy),
    .done          (done),
    .ovf           (ovf)
  );

  typedef struct {
    logic en, oe, rdy, clr;
    logic valid;
    int   data, row, col;
    logic last, busy, done, ovf;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic load_frame(input int base);
    for (int i = 0; i < NE; i++) data_in[DW*i +: DW] = DW'(base + i + 1);
  endtask

  task automatic adv;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_word(input string tag, input int k, input int base);
    chk({tag, ".valid"}, 32'(m_valid), 32'd1);
    chk({tag, ".data"},  m_data,       32'(base + k + 1));
    chk({tag, ".row"},   32'(m_row),   32'(k / N));
    chk({tag, ".col"},   32'(m_col),   32'(k % N));
    chk({tag, ".last"},  32'(m_last),  32'(k == NE - 1));
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".valid"}, 32'(m_valid), 32'd0);
    chk({tag, ".data"},  m_data,       32'd0);
    chk({tag, ".rowcol"}, 32'({m_row, m_col}), 32'd0);
    chk({tag, ".last"},  32'(m_last),  32'd0);
  endtask

  initial begin
    int kexp;
    int cyc;

    //            en oe rdy clr | vld data row col last busy done ovf
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2, 0, 1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3, 0, 2, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4, 0, 3, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4, 0, 3, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5, 0, 4, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 6, 0, 5, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 7, 0, 6, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8, 0, 7, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 9, 1, 0, 1'b0, 1'b1, 1'b0, 1'b0};

    // Reset held with other inputs active
    load_frame(0);
    en = 1'b1; output_enable = 1'b1; m_ready = 1'b1;
    adv(); adv();
    @(negedge clk);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.ovf",  32'(ovf),  32'd0);
    chk_quiet("rst");
    adv();
    rst = 1'b1;

    // Vector table: capture, stalls, en pause, overrun, clear
    for (int i = 0; i < 14; i++) begin
      en = tbl[i].en; output_enable = tbl[i].oe; m_ready = tbl[i].rdy; clr_ovf = tbl[i].clr;
      if (i == 7) load_frame(500);
      @(negedge clk);
      chk($sformatf("tbl%0d.valid", i), 32'(m_valid), 32'(tbl[i].valid));
      chk($sformatf("tbl%0d.data", i),  m_data,       32'(tbl[i].data));
      chk($sformatf("tbl%0d.row", i),   32'(m_row),   32'(tbl[i].row));
      chk($sformatf("tbl%0d.col", i),   32'(m_col),   32'(tbl[i].col));
      chk($sformatf("tbl%0d.last", i),  32'(m_last),  32'(tbl[i].last));
      chk($sformatf("tbl%0d.busy", i),  32'(busy),    32'(tbl[i].busy));
      chk($sformatf("tbl%0d.done", i),  32'(done),    32'(tbl[i].done));
      chk($sformatf("tbl%0d.ovf", i),   32'(ovf),     32'(tbl[i].ovf));
      adv();
    end
    en = 1'b1; output_enable = 1'b0; m_ready = 1'b1; clr_ovf = 1'b0;
    for (int k = 9; k < NE; k++) begin
      @(negedge clk);
      chk_word("full", k, 0);
      adv();
    end
    @(negedge clk);
    chk("full.done", 32'(done), 32'd1);
    chk("full.busy", 32'(busy), 32'd1);
    chk_quiet("full.donecyc");
    adv();
    @(negedge clk);
    chk("full.done_off", 32'(done), 32'd0);
    chk("full.idle", 32'(busy), 32'd0);
    adv();

    // Random backpressure
    load_frame(0);
    output_enable = 1'b1; m_ready = 1'b0;
    adv();
    output_enable = 1'b0;
    kexp = 0; cyc = 0;
    while (kexp < NE && cyc < 2000) begin
      m_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk_word("rand", kexp, 0);
      if (m_ready) kexp++;
      cyc++;
      adv();
    end
    chk("rand.count", 32'(kexp), 32'(NE));
    m_ready = 1'b0;
    @(negedge clk);
    chk("rand.done", 32'(done), 32'd1);
    adv();

    // Overrun at k=10, enable pause at k=20, then clear
    output_enable = 1'b1;
    adv();
    output_enable = 1'b0; m_ready = 1'b1;
    for (int k = 0; k < NE; k++) begin
      if (k == 20) begin
        en = 1'b0;
        for (int p = 0; p < 5; p++) begin
          @(negedge clk);
          chk_quiet("pause");
          chk("pause.busy", 32'(busy), 32'd1);
          chk("pause.done", 32'(done), 32'd0);
          adv();
        end
        en = 1'b1;
      end
      output_enable = (k == 10);
      if (k == 10) load_frame(700);
      @(negedge clk);
      chk_word("ovr", k, 0);
      if (k == 11) chk("ovr.ovf", 32'(ovf), 32'd1);
      adv();
    end
    output_enable = 1'b0;
    @(negedge clk);
    chk("ovr.done", 32'(done), 32'd1);
    adv();
    clr_ovf = 1'b1;
    @(negedge clk);
    chk("ovr.ovf_held", 32'(ovf), 32'd1);
    adv();
    clr_ovf = 1'b0;
    @(negedge clk);
    chk("ovr.ovf_clr", 32'(ovf), 32'd0);
    chk("ovr.idle", 32'(busy), 32'd0);
    adv();

    // Reset mid-frame at k=30, then restart
    load_frame(0);
    output_enable = 1'b1; m_ready = 1'b1;
    adv();
    output_enable = 1'b0;
    for (int k = 0; k <= 30; k++) begin
      output_enable = (k == 5);
      if (k == 30) rst = 1'b0;
      @(negedge clk);
      chk_word("pre", k, 0);
      if (k == 6) chk("pre.ovf", 32'(ovf), 32'd1);
      adv();
    end
    rst = 1'b1; output_enable = 1'b1;
    load_frame(100);
    @(negedge clk);
    chk("midrst.busy", 32'(busy), 32'd0);
    chk("midrst.ovf",  32'(ovf),  32'd0);
    chk_quiet("midrst");
    adv();
    output_enable = 1'b0;
    for (int k = 0; k < NE; k++) begin
      @(negedge clk);
      chk_word("newfrm", k, 100);
      adv();
    end
    @(negedge clk);
    chk("newfrm.done", 32'(done), 32'd1);
    adv();

    // Back-to-back: strobe in the IDLE cycle right after done
    output_enable = 1'b1;
    load_frame(200);
    @(negedge clk);
    chk("b2b.busy_idle", 32'(busy), 32'd0);
    chk("b2b.valid_idle", 32'(m_valid), 32'd0);
    adv();
    output_enable = 1'b0;
    for (int k = 0; k < NE; k++) begin
      @(negedge clk);
      chk_word("b2b", k, 200);
      if (k == 0) chk("b2b.ovf0", 32'(ovf), 32'd0);
      adv();
    end
    @(negedge clk);
    chk("b2b.done", 32'(done), 32'd1);
    chk("b2b.ovf", 32'(ovf), 32'd0);
    adv();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
